// File: rtl/coef_serializer_pkg.sv
// Shared types and helpers for the coefficient serializer: FSM encoding and
// counter-width helper used by the top level and the fetch controller.
package coef_serializer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Counter width that stays at least one bit wide for degenerate sizes.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/coef_fetch_ctrl.sv
// Request/acknowledge fetch controller: holds req_in while collecting
// NR_STAGES coefficients and reports the slot index for each accepted word.
module coef_fetch_ctrl
  import coef_serializer_pkg::*;
#(
  parameter int NR_STAGES = 32,
  parameter int IDXW      = cnt_width(NR_STAGES)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            fetch_start,
  input  logic            ack_in,
  output logic            req_in,
  output logic            wr_en,
  output logic [IDXW-1:0] wr_idx,
  output logic            fetch_done
);

  logic            req_q, req_d;
  logic [IDXW-1:0] idx_q, idx_d;

  // An ack only counts while the request is up; the last slot drops the request.
  always_comb begin
    req_d      = req_q;
    idx_d      = idx_q;
    wr_en      = 1'b0;
    fetch_done = 1'b0;
    if (fetch_start) begin
      req_d = 1'b1;
      idx_d = '0;
    end else if (req_q && ack_in) begin
      wr_en = 1'b1;
      if (idx_q == IDXW'(NR_STAGES - 1)) begin
        req_d      = 1'b0;
        idx_d      = '0;
        fetch_done = 1'b1;
      end else begin
        idx_d = idx_q + IDXW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_q <= 1'b0;
      idx_q <= '0;
    end else begin
      req_q <= req_d;
      idx_q <= idx_d;
    end
  end

  assign req_in = req_q;
  assign wr_idx = idx_q;

endmodule

// File: rtl/coef_serializer.sv
// Fetches NR_STAGES parallel coefficients, then streams them bit-serially to
// the FIR wrapper: last coefficient first, each one LSB first.
module coef_serializer
  import coef_serializer_pkg::*;
#(
  parameter int NR_STAGES = 32,
  parameter int DWIDTH    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              req_in,
  input  logic              ack_in,
  input  logic [0:DWIDTH-1] coef_in,
  output logic              h,
  output logic              h_enabled,
  output logic              busy,
  output logic              done
);

  localparam int IDXW = cnt_width(NR_STAGES);
  localparam int BITW = cnt_width(DWIDTH);

  state_t            state_q, state_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              h_q, h_d;
  logic              h_en_q, h_en_d;
  logic [IDXW-1:0]   coef_cnt_q, coef_cnt_d;
  logic [BITW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [0:DWIDTH-1] coef_buf_q [NR_STAGES];
  logic [0:DWIDTH-1] coef_buf_d [NR_STAGES];

  logic              fetch_start;
  logic              wr_en;
  logic [IDXW-1:0]   wr_idx;
  logic              fetch_done;

  assign fetch_start = (state_q == ST_IDLE) && start;

  coef_fetch_ctrl #(
    .NR_STAGES (NR_STAGES),
    .IDXW      (IDXW)
  ) u_fetch (
    .clk         (clk),
    .rst         (rst),
    .fetch_start (fetch_start),
    .ack_in      (ack_in),
    .req_in      (req_in),
    .wr_en       (wr_en),
    .wr_idx      (wr_idx),
    .fetch_done  (fetch_done)
  );

  always_comb begin
    coef_buf_d = coef_buf_q;
    if (wr_en) coef_buf_d[wr_idx] = coef_in;
  end

  // Buffer contents are don't-care after reset, so it has no reset branch.
  always_ff @(posedge clk) begin
    coef_buf_q <= coef_buf_d;
  end

  always_comb begin
    state_d    = state_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    h_d        = 1'b0;
    h_en_d     = 1'b0;
    coef_cnt_d = coef_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_FETCH;
          busy_d  = 1'b1;
        end
      end
      ST_FETCH: begin
        // The final word is still being written, so its LSB comes straight from coef_in.
        if (fetch_done) begin
          state_d    = ST_SHIFT;
          h_en_d     = 1'b1;
          h_d        = coef_in[DWIDTH-1];
          coef_cnt_d = IDXW'(NR_STAGES - 1);
          bit_cnt_d  = BITW'(DWIDTH - 1);
        end
      end
      ST_SHIFT: begin
        if (coef_cnt_q == '0 && bit_cnt_q == '0) begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          if (bit_cnt_q == '0) begin
            coef_cnt_d = coef_cnt_q - IDXW'(1);
            bit_cnt_d  = BITW'(DWIDTH - 1);
          end else begin
            bit_cnt_d = bit_cnt_q - BITW'(1);
          end
          h_en_d = 1'b1;
          h_d    = coef_buf_q[coef_cnt_d][bit_cnt_d];
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      h_q        <= 1'b0;
      h_en_q     <= 1'b0;
      coef_cnt_q <= '0;
      bit_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      h_q        <= h_d;
      h_en_q     <= h_en_d;
      coef_cnt_q <= coef_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
    end
  end

  assign h         = h_q;
  assign h_enabled = h_en_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_coef_serializer.sv
// Scoreboard bench for coef_serializer: stimulus queues expected words and
// done timing, a negedge monitor rebuilds the FIR h_in register and compares.
module tb_coef_serializer;

  localparam int NR  = 32;
  localparam int DW  = 16;
  localparam int CW  = NR * DW;
  localparam int LAT = NR + CW + 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          ack_in = 1'b0;
  logic [0:DW-1] coef_in = '0;
  logic          req_in, h, h_enabled, busy, done;

  int tests = 0;
  int fails = 0;

  logic [0:DW-1] src_mem [NR];
  logic [0:DW-1] exp_mem [NR];
  logic [0:DW-1] exp_q [$];
  int            done_q [$];

  int       cyc = 0;
  int       accept_cnt = 0;
  int       src_idx = 0;
  bit       random_gaps = 1'b0;
  int       gap_left = 0;
  bit       req_fall_chk = 1'b0;
  logic [0:CW-1] h_in_model;
  int       en_cnt = 0;
  int       bit_in_word = 0;
  logic [0:DW-1] acc;
  int       first_one = -1;
  int       last_one = -1;
  int       done_seen = 0;

  always #5 clk = ~clk;

  coef_serializer #(.NR_STAGES(NR), .DWIDTH(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .req_in    (req_in),
    .ack_in    (ack_in),
    .coef_in   (coef_in),
    .h         (h),
    .h_enabled (h_enabled),
    .busy      (busy),
    .done      (done)
  );

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Count accepted handshakes on the same edge the DUT samples them.
  always @(posedge clk) begin
    cyc++;
    if (rst && req_in && ack_in) begin
      accept_cnt++;
      src_idx++;
      if (accept_cnt == NR) req_fall_chk = 1'b1;
    end
  end

  // Source: either ack tied high (garbage data once the table is exhausted) or random gaps.
  always @(negedge clk) begin
    if (!rst) begin
      ack_in   = 1'b0;
      gap_left = 0;
    end else if (!random_gaps) begin
      ack_in  = 1'b1;
      coef_in = (src_idx < NR) ? src_mem[src_idx] : 16'hDEAD;
    end else if (req_in && src_idx < NR) begin
      if (gap_left > 0) begin
        ack_in = 1'b0;
        gap_left--;
      end else begin
        ack_in   = 1'b1;
        coef_in  = src_mem[src_idx];
        gap_left = $urandom_range(0, 5);
      end
    end else begin
      ack_in  = 1'b0;
      coef_in = 16'hBEEF;
    end
  end

  always @(negedge clk) begin
    logic [0:DW-1] e;
    int            ec;
    if (!rst) begin
      en_cnt       = 0;
      bit_in_word  = 0;
      req_fall_chk = 1'b0;
    end else begin
      if (req_fall_chk) begin
        req_fall_chk = 1'b0;
        check_output("req_fall", {31'd0, req_in}, 32'd0);
        check_output("first_shift", {31'd0, h_enabled}, 32'd1);
      end
      if (h_enabled) begin
        h_in_model = {h, h_in_model[0:CW-2]};
        if (h === 1'b1) begin
          if (first_one < 0) first_one = en_cnt;
          last_one = en_cnt;
        end
        acc[DW-1-bit_in_word] = h;
        bit_in_word++;
        en_cnt++;
        if (bit_in_word == DW) begin
          bit_in_word = 0;
          if (exp_q.size() == 0) begin
            check_output("unexpected_word", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            check_output("word", {16'd0, acc}, {16'd0, e});
          end
        end
      end
      if (done) begin
        done_seen++;
        if (done_q.size() == 0) begin
          check_output("unexpected_done", 32'd1, 32'd0);
        end else begin
          ec = done_q.pop_front();
          if (ec >= 0) check_output("latency", cyc, ec);
        end
        check_output("shift_len", en_cnt, CW);
        check_output("accept_cnt", accept_cnt, NR);
        check_output("done_outputs", {28'd0, busy, h, h_enabled, req_in}, 32'd0);
        check_output("words_left", exp_q.size(), 32'd0);
        for (int k = 0; k < NR; k++)
          check_output($sformatf("h_in_slice%0d", k), {16'd0, h_in_model[k*DW +: DW]}, {16'd0, exp_mem[k]});
        en_cnt = 0;
      end
    end
  end

  task automatic apply_stimulus(input bit gaps);
    @(negedge clk);
    random_gaps = gaps;
    src_idx     = 0;
    accept_cnt  = 0;
    gap_left    = 0;
    first_one   = -1;
    last_one    = -1;
    for (int k = 0; k < NR; k++) exp_mem[k] = src_mem[k];
    for (int k = NR - 1; k >= 0; k--) exp_q.push_back(src_mem[k]);
    // Start cycle and done cycle both count toward LAT, so done lands LAT-1 edges later.
    done_q.push_back(gaps ? -1 : cyc + LAT - 1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int n = 0;
    while (done_seen < target && n < 4 * LAT) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (done_seen < target) check_output("done_timeout", done_seen, target);
  endtask

  task automatic wait_shift(input int target);
    int n = 0;
    while (en_cnt < target && n < 4 * LAT) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (en_cnt < target) check_output("shift_timeout", en_cnt, target);
  endtask

  initial begin
    h_in_model = '0;
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_output("rst_req_in", {31'd0, req_in}, 32'd0);
    check_output("rst_h", {31'd0, h}, 32'd0);
    check_output("rst_h_enabled", {31'd0, h_enabled}, 32'd0);
    check_output("rst_busy", {31'd0, busy}, 32'd0);
    check_output("rst_done", {31'd0, done}, 32'd0);
    rst = 1'b1;

    // Only coef 0 MSB set: it must be the very last bit shifted.
    for (int k = 0; k < NR; k++) src_mem[k] = 16'h0000;
    src_mem[0] = 16'h8000;
    apply_stimulus(1'b0);
    wait_done(1);
    check_output("msb_first_one", first_one, CW - 1);
    check_output("msb_last_one", last_one, CW - 1);

    // Only coef NR-1 LSB set: it must be the very first bit shifted.
    for (int k = 0; k < NR; k++) src_mem[k] = 16'h0000;
    src_mem[NR-1] = 16'h0001;
    apply_stimulus(1'b0);
    wait_done(2);
    check_output("lsb_first_one", first_one, 0);
    check_output("lsb_last_one", last_one, 0);
    // A start coinciding with the DONE cycle is dropped.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    check_output("start_in_done_busy", {31'd0, busy}, 32'd0);
    check_output("start_in_done_req", {31'd0, req_in}, 32'd0);
    @(negedge clk);
    #1;
    check_output("start_in_done_busy2", {31'd0, busy}, 32'd0);

    for (int k = 0; k < NR; k++) src_mem[k] = DW'(k + 1);
    apply_stimulus(1'b1);
    wait_done(3);

    // Extra starts during FETCH and SHIFT must not disturb timing or data.
    for (int k = 0; k < NR; k++) src_mem[k] = DW'(k * 3 + 7);
    apply_stimulus(1'b0);
    repeat (5) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_shift(200);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(4);

    // Reset in the middle of shifting, then a clean reload.
    for (int k = 0; k < NR; k++) src_mem[k] = 16'hA5A5 ^ DW'(k);
    apply_stimulus(1'b0);
    wait_shift(100);
    rst = 1'b0;
    #1;
    check_output("midrst_h_enabled", {31'd0, h_enabled}, 32'd0);
    check_output("midrst_busy", {31'd0, busy}, 32'd0);
    check_output("midrst_req_in", {31'd0, req_in}, 32'd0);
    exp_q.delete();
    done_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < NR; k++) src_mem[k] = 16'h1234 + DW'(k * 16'h0101);
    apply_stimulus(1'b0);
    wait_done(5);

    // Back-to-back: new load issued the cycle right after done.
    for (int k = 0; k < NR; k++) src_mem[k] = 16'hFFFF - DW'(k);
    apply_stimulus(1'b0);
    wait_done(6);

    repeat (20) @(negedge clk);
    #1;
    check_output("total_done", done_seen, 6);
    check_output("final_words_left", exp_q.size(), 32'd0);
    check_output("final_done_left", done_q.size(), 32'd0);
    check_output("final_busy", {31'd0, busy}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/coef_serializer.md
Name: coef_serializer

Overview:
Upstream feeder for the FIR wrapper's serial coefficient port. It fetches NR_STAGES parallel coefficients from a host or ROM over a req/ack handshake and buffers them. It then streams all CWIDTH bits out on h/h_enabled, in the order that leaves coefficient k in slice [k*DWIDTH : k*DWIDTH+DWIDTH-1] of the filter's h_in register, MSB at the lowest index. It pulses done when the load completes.

Parameters:
NR_STAGES, 32, number of filter taps / coefficients
DWIDTH, 16, coefficient width in bits
CWIDTH, NR_STAGES*DWIDTH, total serialized bits (derived, not overridden)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
start  input  1  single-cycle request to begin a full coefficient load
req_in  output  1  block requests coefficients from the source
ack_in  input  1  source presents a valid coef_in this cycle
coef_in  input  [0:DWIDTH-1]  coefficient word; index 0 is the MSB
h  output  1  serial coefficient bit to the FIR wrapper
h_enabled  output  1  shift-enable to the FIR wrapper
busy  output  1  high from accepted start until done
done  output  1  one-cycle pulse when the last bit has been shifted

Behaviour:
- Reset (rst low, async): state IDLE; req_in, h, h_enabled, busy, done = 0; counters = 0. The buffer contents are don't-care.
- All outputs are registered.
- FSM states: IDLE, FETCH, SHIFT, DONE.
- IDLE: start=1 -> FETCH; busy=1 and req_in=1 from the next cycle. Any other input is ignored.
- FETCH:
  - req_in is held high.
  - Each cycle with req_in && ack_in captures coef_in into slot idx (idx counts 0..NR_STAGES-1), then idx increments.
  - ack_in while req_in=0 is ignored.
  - Gaps between acks of any length are allowed.
  - On the ack that fills slot NR_STAGES-1: req_in=0 next cycle, state -> SHIFT.
- SHIFT:
  - h_enabled=1 for exactly CWIDTH consecutive cycles, with no gaps.
  - The first shift cycle is the cycle after the final ack.
  - Bit order: coefficient NR_STAGES-1 first, down to coefficient 0 last.
  - Within each coefficient, LSB first (coef_in index DWIDTH-1) and MSB last (index 0).
  - A bit counter (0..DWIDTH-1) and a coefficient counter (NR_STAGES-1..0) track position; the last shift cycle is coefficient 0, bit 0.
- DONE: one cycle, with h_enabled=0, h=0, done=1, busy=0. Returns to IDLE.
- start while busy (FETCH, SHIFT, DONE): ignored; it does not restart or queue.
- start in the same cycle as the DONE state: ignored. A new start is accepted from IDLE only, so back-to-back loads need start on the cycle after done or later.
- h is 0 whenever h_enabled=0.
- Reset mid-operation: outputs drop asynchronously. The filter's shift register then holds a partial or garbage load, so the host must issue a fresh start.
- Total latency from start to done: 1 + (cycles to collect NR_STAGES acks) + CWIDTH + 1. With ack_in tied high, this is NR_STAGES + CWIDTH + 2 cycles from the start edge.

Decomposition:
- Shared package: FSM state encoding; IDXW = clog2(NR_STAGES); BITW = clog2(DWIDTH).
- Buffer: a register array of NR_STAGES x DWIDTH, written by index and read by coefficient counter plus bit counter. It is kept inline.
- One natural sub-module: coef_fetch_ctrl, containing the req/ack handshake and idx counter, emitting fetch_done. The shift FSM stays in the top level.

Test Plan:
- Single-bit order check: coef 0 = 0x8000, all others 0, ack_in tied high. Required: h=1 only on the last shift cycle (shift index 511), and done the next cycle.
- LSB-first check: coef 31 = 0x0001, all others 0. Required: h=1 only on the first shift cycle (index 0); h_enabled is high exactly 512 cycles.
- Full load with a reference shift-register model: coef k = k+1, with random ack gaps of 0-5 cycles. Required: model h_in slice k equals k+1 for all k; req_in falls the cycle after the 32nd ack; no extra coefficient is captured.
- Start ignored while busy: pulse start during FETCH and during SHIFT. Required: the acceptance count stays at 32, one done pulse, timing unchanged.
- Reset mid-shift: assert rst at shift cycle 100. Required: h_enabled, busy, req_in go 0 immediately. After release, start yields a full 512-cycle load with correct data.
- Back-to-back loads: start the cycle after done with new values coef k = 0xFFFF - k. Required: the second load fully overwrites the model; done pulses twice.
